// File: rtl/msk_rx_pkg.sv
// Shared MSK receiver defaults and saturating-add helper.
// Latency: n/a (package). Backpressure: n/a.
// Lock-detector defaults are consumed only when LOOP_FILTER_LOCK_DET_EN is defined.
package msk_rx_pkg;

  localparam int EW_DEF          = 24;
  localparam int FW_DEF          = 32;
  localparam int LOCK_THRESH_DEF = 'h000800;
  localparam int LOCK_COUNT_DEF  = 64;

  // Widest signed word sat_add handles; callers sign-extend into it and truncate back.
  localparam int SAT_MAXW = 64;

  // Signed a+b clamped to the w-bit two's-complement range; the sum is formed one bit wider so it never wraps.
  function automatic logic signed [SAT_MAXW-1:0] sat_add(
    input logic signed [SAT_MAXW-1:0] a,
    input logic signed [SAT_MAXW-1:0] b,
    input int unsigned                w
  );
    logic signed [SAT_MAXW:0] sum;
    logic signed [SAT_MAXW:0] one;
    logic signed [SAT_MAXW:0] hi;
    logic signed [SAT_MAXW:0] lo;
    one = {{SAT_MAXW{1'b0}}, 1'b1};
    sum = {a[SAT_MAXW-1], a} + {b[SAT_MAXW-1], b};
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (sum > hi)
      sat_add = hi[SAT_MAXW-1:0];
    else if (sum < lo)
      sat_add = lo[SAT_MAXW-1:0];
    else
      sat_add = sum[SAT_MAXW-1:0];
  endfunction

endpackage

// File: rtl/lock_detect.sv
// Carrier lock detector: |phase_err| window compare with saturating consecutive-hit counter.
// Latency: 3 clk from err_valid to locked update, aligned with the filter output strobe.
// Backpressure: none; one decision per err_valid.
import msk_rx_pkg::*;

module lock_detect #(
  parameter int          EW          = EW_DEF,
  parameter int unsigned LOCK_THRESH = LOCK_THRESH_DEF,
  parameter int unsigned LOCK_COUNT  = LOCK_COUNT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 err_valid,
  input  logic signed [EW-1:0] phase_err,
  output logic                 locked
);

  localparam int          CW     = $clog2(LOCK_COUNT + 1);
  localparam logic [EW:0] THR    = (EW + 1)'(LOCK_THRESH);
  localparam logic [CW-1:0] CMAX = CW'(LOCK_COUNT);
  localparam logic [CW-1:0] CPRE = CW'(LOCK_COUNT - 1);

  logic [EW-1:0] mag;
  logic          win_s1;
  logic          s1_vld;
  logic          hit_s2;
  logic          s2_vld;
  logic [CW-1:0] cnt;

  // Most-negative input has no positive twin, so it saturates to the largest magnitude.
  always_comb begin
    mag = phase_err;
    if (phase_err == {1'b1, {(EW-1){1'b0}}})
      mag = {1'b0, {(EW-1){1'b1}}};
    else if (phase_err[EW-1])
      mag = -phase_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_s1 <= 1'b0;
      s1_vld <= 1'b0;
      hit_s2 <= 1'b0;
      s2_vld <= 1'b0;
      cnt    <= '0;
      locked <= 1'b0;
    end else begin
      s1_vld <= err_valid;
      if (err_valid)
        win_s1 <= ({1'b0, mag} < THR);
      s2_vld <= s1_vld;
      if (s1_vld) begin
        if (win_s1) begin
          if (cnt != CMAX)
            cnt <= cnt + 1'b1;
          hit_s2 <= (cnt >= CPRE);
        end else begin
          cnt    <= '0;
          hit_s2 <= 1'b0;
        end
      end
      if (s2_vld)
        locked <= hit_s2;
    end
  end

endmodule

// File: rtl/loop_filter.sv
// PI carrier-loop filter: phase error -> saturated NCO frequency word; lock detector under LOOP_FILTER_LOCK_DET_EN.
// Latency: 3 clk err_valid -> freq_valid, 1 sample/clk.
// Backpressure: none; every err_valid yields exactly one freq_valid.
import msk_rx_pkg::*;

module loop_filter #(
  parameter int          EW          = EW_DEF,
  parameter int          FW          = FW_DEF,
  parameter int          KP_SHIFT    = 4,
  parameter int          KI_SHIFT    = 10,
  parameter int unsigned LOCK_THRESH = LOCK_THRESH_DEF,
  parameter int unsigned LOCK_COUNT  = LOCK_COUNT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 err_valid,
  input  logic signed [EW-1:0] phase_err,
  input  logic                 hold,
  input  logic                 clear,
  output logic                 freq_valid,
  output logic signed [FW-1:0] freq_word,
  output logic                 locked
);

  logic signed [FW-1:0] err_ext;
  logic signed [FW-1:0] p_s1;
  logic signed [FW-1:0] i_s1;
  logic signed [FW-1:0] p_s2;
  logic signed [FW-1:0] integ;
  logic                 s1_vld;
  logic                 s2_vld;

  assign err_ext = FW'(phase_err);

  // clear wins over hold and acts even without a sample in flight; the output only moves on a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_s1       <= '0;
      i_s1       <= '0;
      s1_vld     <= 1'b0;
      p_s2       <= '0;
      s2_vld     <= 1'b0;
      integ      <= '0;
      freq_valid <= 1'b0;
      freq_word  <= '0;
    end else begin
      s1_vld <= err_valid;
      if (err_valid) begin
        p_s1 <= err_ext >>> KP_SHIFT;
        i_s1 <= err_ext >>> KI_SHIFT;
      end
      s2_vld <= s1_vld;
      if (s1_vld)
        p_s2 <= p_s1;
      if (clear)
        integ <= '0;
      else if (s1_vld && !hold)
        integ <= FW'(sat_add(SAT_MAXW'(integ), SAT_MAXW'(i_s1), FW));
      freq_valid <= s2_vld;
      if (s2_vld)
        freq_word <= FW'(sat_add(SAT_MAXW'(integ), SAT_MAXW'(p_s2), FW));
    end
  end

`ifdef LOOP_FILTER_LOCK_DET_EN
  lock_detect #(
    .EW          (EW),
    .LOCK_THRESH (LOCK_THRESH),
    .LOCK_COUNT  (LOCK_COUNT)
  ) u_lock_detect (
    .clk       (clk),
    .rst       (rst),
    .err_valid (err_valid),
    .phase_err (phase_err),
    .locked    (locked)
  );
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_loop_filter.sv
// Randomized self-checking bench for loop_filter against a sample-level PI reference model.
// A second instance (FW=24, unity gains) exercises output saturation.
module tb_loop_filter;

  localparam int    EW   = 24;
  localparam int    FW   = 32;
  localparam int    KP   = 4;
  localparam int    KI   = 10;
  localparam int    LCNT = 64;
  localparam longint THR = 'h800;
`ifdef LOOP_FILTER_LOCK_DET_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 err_valid;
  logic signed [EW-1:0] phase_err;
  logic                 hold;
  logic                 clear;
  logic                 freq_valid;
  logic signed [FW-1:0] freq_word;
  logic                 locked;
  logic                 sat_vld;
  logic                 sat_fv;
  logic signed [23:0]   sat_fw;
  logic                 sat_locked;

  always #5 clk = ~clk;

  loop_filter #(
    .EW(EW), .FW(FW), .KP_SHIFT(KP), .KI_SHIFT(KI),
    .LOCK_THRESH(24'h000800), .LOCK_COUNT(LCNT)
  ) dut (
    .clk(clk), .rst(rst), .err_valid(err_valid), .phase_err(phase_err),
    .hold(hold), .clear(clear), .freq_valid(freq_valid),
    .freq_word(freq_word), .locked(locked)
  );

  loop_filter #(
    .EW(24), .FW(24), .KP_SHIFT(0), .KI_SHIFT(0),
    .LOCK_THRESH(24'h000800), .LOCK_COUNT(LCNT)
  ) dut_sat (
    .clk(clk), .rst(rst), .err_valid(sat_vld), .phase_err(phase_err),
    .hold(hold), .clear(clear), .freq_valid(sat_fv),
    .freq_word(sat_fw), .locked(sat_locked)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state, sample-ordered
  longint m_integ;
  longint prev_e;
  bit     prev_v;
  bit     pend_h;
  bit     pend_c;
  int     lcnt;
  longint exp_word;
  bit     exp_lock;
  bit     q_v[$];
  longint q_w[$];
  bit     q_l[$];

  function automatic longint floor_shift(longint e, int k);
    longint d;
    d = longint'(1) <<< k;
    if (e >= 0) return e / d;
    return -((-e + d - 1) / d);
  endfunction

  function automatic longint clamp(longint x, int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_integ  = 0;
    prev_e   = 0;
    prev_v   = 1'b0;
    pend_h   = 1'b0;
    pend_c   = 1'b0;
    lcnt     = 0;
    exp_word = 0;
    exp_lock = 1'b0;
    q_v.delete();
    q_w.delete();
    q_l.delete();
  endtask

  // One clock: drive a new sample, apply the previous sample's hold/clear, then check outputs.
  task automatic step(input bit v, input logic signed [EW-1:0] e, input bit h, input bit c);
    longint w;
    longint a;
    bit     l;
    bit     pv;
    err_valid = v;
    phase_err = e;
    hold      = pend_h;
    clear     = pend_c;
    w = 0;
    l = 1'b0;
    if (prev_v) begin
      if (pend_c)
        m_integ = 0;
      else if (!pend_h)
        m_integ = clamp(m_integ + floor_shift(prev_e, KI), FW);
      w = clamp(m_integ + floor_shift(prev_e, KP), FW);
      a = (prev_e < 0) ? -prev_e : prev_e;
      if (a > (longint'(1) <<< (EW - 1)) - 1)
        a = (longint'(1) <<< (EW - 1)) - 1;
      if (a < THR)
        lcnt = (lcnt < LCNT) ? lcnt + 1 : LCNT;
      else
        lcnt = 0;
      l = LOCK_EN && (lcnt == LCNT);
    end else if (pend_c) begin
      m_integ = 0;
    end
    q_v.push_back(prev_v);
    q_w.push_back(w);
    q_l.push_back(l);
    prev_v = v;
    prev_e = e;
    pend_h = h;
    pend_c = c;
    @(posedge clk);
    #1;
    pv = 1'b0;
    if (q_v.size() == 2) begin
      pv = q_v.pop_front();
      w  = q_w.pop_front();
      l  = q_l.pop_front();
      if (pv) begin
        exp_word = w;
        exp_lock = l;
      end
    end
    chk("freq_valid", freq_valid, pv);
    chk("freq_word", freq_word, exp_word);
    chk("locked", locked, exp_lock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must drop before the next edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_freq_valid", freq_valid, 0);
    chk("rst_freq_word", freq_word, 0);
    chk("rst_locked", locked, 0);
    chk("rst_sat_valid", sat_fv, 0);
    chk("rst_sat_word", sat_fw, 0);
    err_valid = 1'b0;
    hold      = 1'b0;
    clear     = 1'b0;
    sat_vld   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int   t;
    bit   v;
    logic signed [EW-1:0] e;
    rst       = 1'b0;
    err_valid = 1'b0;
    phase_err = '0;
    hold      = 1'b0;
    clear     = 1'b0;
    sat_vld   = 1'b0;
    model_reset();
    async_reset();
    idle(3);

    // Gain: two pulses of 0x4000 -> 1040 then 1056
    step(1'b1, 24'h004000, 1'b0, 1'b0);
    step(1'b1, 24'h004000, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("gain_first", freq_word, 1040);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("gain_second", freq_word, 1056);
    idle(2);

    // Negative rounding toward -inf, then clear with a zero sample
    step(1'b1, '0, 1'b0, 1'b1);
    step(1'b1, -24'sd1, 1'b0, 1'b0);
    idle(3);
    chk("neg_round", freq_word, -2);
    step(1'b1, '0, 1'b0, 1'b1);
    idle(3);
    chk("clear_zero", freq_word, 0);

    // Hold freezes the integrator, proportional path stays live
    for (int k = 0; k < 3; k++) step(1'b1, 24'h004000, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("hold_first", freq_word, 1024);
    idle(2);
    chk("hold_last", freq_word, 1024);

    // Clear with no sample in flight, then back-to-back ramp
    step(1'b1, 24'h004000, 1'b0, 1'b0);
    idle(3);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) step(1'b1, EW'(k <<< 10), 1'b0, 1'b0);
    idle(3);
    chk("ramp_final", freq_word, 36 + 512);

    // Random stream with a reset dropped in mid-flight
    for (int k = 0; k < 300; k++) begin
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: begin t = int'($urandom_range(0, 4094)) - 2047; e = EW'(t); end
        1: e = EW'($urandom());
        2: e = 24'h800000;
        default: begin t = int'($urandom_range(0, 65535)) - 32768; e = EW'(t); end
      endcase
      step(v, e, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
      if (k == 150) begin
        step(1'b1, 24'h004000, 1'b0, 1'b0);
        async_reset();
      end
    end
    idle(3);

    // Saturation on the FW=24 unity-gain instance: positive then negative rails
    for (int k = 0; k < 8; k++) begin
      sat_vld = (k < 4);
      step(1'b0, (k < 4) ? 24'h7FFFFF : 24'h000000, 1'b0, 1'b0);
      if (k >= 2 && k < 6) begin
        chk("sat_pos_valid", sat_fv, 1);
        chk("sat_pos_word", sat_fw, 64'sd8388607);
      end
    end
    for (int k = 0; k < 8; k++) begin
      sat_vld = (k < 4);
      step(1'b0, (k < 4) ? 24'h800000 : 24'h000000, 1'b0, 1'b0);
      if (k >= 2 && k < 6)
        chk("sat_neg_word", sat_fw, -64'sd8388608);
    end
    sat_vld = 1'b0;

    // Lock: reset the run with an out-of-window sample, 63 in-window, then the 64th
    step(1'b1, 24'h000800, 1'b0, 1'b0);
    for (int k = 0; k < 63; k++) begin
      t = int'($urandom_range(0, 4094)) - 2047;
      step(1'b1, EW'(t), 1'b0, 1'b0);
    end
    idle(3);
    chk("lock_63", locked, 0);
    step(1'b1, 24'h0007FF, 1'b0, 1'b0);
    idle(2);
    chk("lock_64", locked, LOCK_EN);
    step(1'b1, 24'h000800, 1'b0, 1'b0);
    idle(1);
    chk("lock_hold_pre", locked, LOCK_EN);
    idle(1);
    chk("lock_drop", locked, 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/loop_filter.md
# loop_filter

Second-order proportional-integral (PI) loop filter for the MSK receiver carrier-recovery loop. It sits directly downstream of the decision-directed phase detector and consumes its `err_valid` and `phase_err` symbol-rate stream. It produces a signed NCO frequency-correction word with saturation, integrator hold/clear controls and an optional lock indicator. The whole block runs on the 200 MHz sample clock.

## Interface
- `EW`, default 24: phase-error width, signed.
- `FW`, default 32: integrator and output width, signed. Must satisfy FW ≥ EW.
- `KP_SHIFT`, default 4: proportional gain = 2^-KP_SHIFT.
- `KI_SHIFT`, default 10: integral gain = 2^-KI_SHIFT.
- `LOCK_THRESH`, default 24'h000800: lock window on |phase_err|.
- `LOCK_COUNT`, default 64: consecutive in-window errors required to declare lock.
- Reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  sample clock.
- `rst`  in  1  asynchronous, active-high reset.
- `err_valid`  in  1  qualifies `phase_err`; single-cycle pulses, back-to-back allowed.
- `phase_err`  in  EW  signed phase error.
- `hold`  in  1  freezes the integrator; the proportional path stays live.
- `clear`  in  1  synchronous integrator clear.
- `freq_valid`  out  1  one-cycle strobe qualifying `freq_word`.
- `freq_word`  out  FW  signed NCO correction; held between strobes.
- `locked`  out  1  lock status.

## Operation
- Cycle N+1: register `p = sext(phase_err) >>> KP_SHIFT` and `i = sext(phase_err) >>> KI_SHIFT`, plus valid v1. Sign-extend to FW before shifting; the shift is arithmetic (rounds toward -inf, so -1 >>> k = -1).
- Cycle N+2 (on v1):
  - `clear`=1: `integ` ← 0.
  - Else `hold`=1: `integ` unchanged.
  - Else `integ` ← sat(integ + i).
  - `p` is delayed to `p_d`, valid v2.
- Cycle N+3 (on v2): `freq_word` ← sat(integ + p_d), `freq_valid` ← 1.
- sat(): clamp to [-2^(FW-1), 2^(FW-1)-1]. Compute in FW+1 bits; never wrap.
- `clear` and `hold` are sampled in the cycle v1 is high. `clear` takes priority over `hold`. When v1 is low, `clear` still zeroes `integ` immediately, but `freq_word` only changes on the next strobe.
- There is no backpressure; every `err_valid` produces exactly one `freq_valid` three cycles later.

## Timing
- Latency is 3 clk from `err_valid` to `freq_valid`. Throughput is 1 sample/clk.
- Reset values: `freq_valid`=0, `freq_word`=0, `locked`=0. `integ`, the pipeline registers and the lock counter are all 0.
- Reset asserted mid-operation kills any in-flight samples; no `freq_valid` is issued for them.
- `locked` updates in the same cycle as the `freq_valid` for that sample (N+3).

## Configuration
- `LOOP_FILTER_LOCK_DET_EN` defined:
  - Compute |phase_err|, with the most-negative value saturated to 2^(EW-1)-1.
  - Each sample with |phase_err| < LOCK_THRESH increments a counter, saturating at LOCK_COUNT. The sample that brings the count to LOCK_COUNT sets `locked`=1.
  - Any sample with |phase_err| ≥ LOCK_THRESH zeroes the counter and sets `locked`=0 at that sample's N+3.
  - `clear` does not affect lock.
- Macro undefined: the counter and comparator are not synthesized, and `locked` is tied to 0.

## Structure
- Shared package `msk_rx_pkg` holds:
  - the default widths EW/FW;
  - a parameterized `sat_add` function for signed add with clamp;
  - the lock-detector defaults.
- Sub-module `lock_detect` (EW, LOCK_THRESH, LOCK_COUNT) holds the abs, compare and counter logic, with its own 3-cycle valid alignment. It is instantiated only under `LOOP_FILTER_LOCK_DET_EN`.

## Test plan
- Reset: assert `rst` asynchronously mid-stream → all outputs 0 within the same cycle, and no stray `freq_valid` after release.
- Gain check with defaults: two pulses of `phase_err`=24'h004000 → `freq_word`=1040 at N+3, then 1056 on the second strobe.
- Negative rounding: `phase_err`=-1 → `i`=-1, `p`=-1, so `freq_word`=-2. Then `clear` pulsed with a sample of 0 → `freq_word`=0.
- Hold and saturation:
  - `hold`=1 with 24'h004000 → `freq_word` stays at 1024 on each strobe.
  - With FW=24, KI_SHIFT=0, KP_SHIFT=0, feed repeated 24'h7FFFFF → `freq_word` clamps to 24'h7FFFFF with no wrap.
- Back-to-back: `err_valid` held high for 8 clk with a ramp 1..8 <<< 10 → 8 consecutive `freq_valid` strobes. The integrator reaches 36, checked against the reference model.
- Lock (macro on), with LOCK_COUNT=64:
  - 63 in-window samples → `locked`=0; the 64th sets `locked`=1.
  - Then one sample of 24'h000800 → `locked`=0 at that sample's N+3.
